sevenseg_capture: RTL
=====================

Name: sevenseg_capture

Overview:
- Receive-side counterpart of the team's hex-to-7-segment encoder.
- Monitors a multiplexed 4-digit 7-segment display bus: segment lines plus active-low digit anodes.
- Recovers the hex nibble shown on each digit and qualifies it with per-digit stability, blank and illegal-glyph flags.
- Sits in the board self-test path, and as a loopback checker beside the display driver.

Parameters:
- SETTLE_CYC, 4: cycles a single anode must stay unchanged after synchronisation before segments are sampled; legal 1..255.
- MATCH_N, 2: consecutive identical decodes of one digit required before that digit's output updates; legal 1..15.
- TIMEOUT_CYC, 1000: cycles with no valid single-anode selection before all digits are declared stale; legal 2..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- seg_in  in  7  segment lines {a,b,c,d,e,f,g}, bit6=a, bit0=g; 1 = lit; asynchronous to clk
- dp_in  in  1  decimal-point line, 1 = lit; asynchronous
- an_in  in  4  digit anodes, active-low, bit0 = rightmost digit; asynchronous
- value  out  16  recovered nibbles, value[4k+3:4k] = digit k
- digit_valid  out  4  digit k holds a qualified hex glyph
- digit_blank  out  4  digit k qualified as all segments off (7'h00)
- digit_illegal  out  4  digit k qualified as a non-blank pattern outside the glyph table
- dp_out  out  4  per-digit decimal point (see Optional Feature)
- upd  out  1  one-cycle pulse when any output bit for any digit changes
- stale  out  1  scan timeout active

Behaviour:
- Reset (synchronous, active-high, clk domain): every output is 0. Synchronisers, match counters and stored candidates are cleared. FSM goes to IDLE.
  - Reset asserted mid-scan discards any partial match.
- Input sync: seg_in, dp_in and an_in each pass through 2 flops. Everything below uses the synchronised copies.
- Glyph table (hex digit -> seg):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=73, A=77, b=1F, C=4E, d=3D, E=4F, F=47
  - Decode is pure lookup. 00 = blank. Any other code = illegal.
- FSM states:
  - IDLE: wait for an_sync to have exactly one 0 bit. Then latch sel = that index, clear settle count, go to SETTLE.
  - SETTLE: count cycles while an_sync is unchanged.
    - An change -> IDLE.
    - Count reaches SETTLE_CYC -> SAMPLE.
  - SAMPLE, one cycle: decode seg_sync into class (hex/blank/illegal) plus nibble.
    - If class+nibble equals digit sel's candidate, increment its match count, saturating at MATCH_N.
    - Otherwise load the new candidate and set match=1.
    - When match reaches MATCH_N and the candidate differs from the committed outputs, commit it to value/flags of digit sel and pulse upd on the following cycle.
    - Go to WAIT_REL.
  - WAIT_REL: stay until an_sync differs from the latched pattern, then go to IDLE.
    - The same digit held lit produces exactly one sample.
- Committed flags are one-hot per digit: valid, blank, illegal. On a blank or illegal commit the digit's value nibble is 0.
- Anode boundary cases:
  - All-high: treated as no selection.
  - Multiple-low: treated as no selection, never sampled.
- Timeout:
  - Counter resets on every SAMPLE.
  - On reaching TIMEOUT_CYC, clear all digit_valid/blank/illegal bits and value. Set stale=1 and pulse upd once.
  - stale clears on the next SAMPLE.
  - The counter saturates and does not wrap.
- Latency: input edge to upd = 2 (sync) + 1 (IDLE) + SETTLE_CYC + 1 (SAMPLE) + 1 cycles, for the MATCH_N-th matching scan.
- Simultaneous events: a timeout reached in the same cycle as SAMPLE is ignored, because SAMPLE wins.

Optional Feature:
- Macro SEVENSEG_CAPTURE_DP_EN.
- Defined: dp_sync is sampled in SAMPLE and folded into the candidate comparison. The committed bit goes to dp_out[sel]. A DP change alone counts as a value change and pulses upd.
- Undefined: dp_in is ignored, dp_out is tied to 4'b0000, and DP never affects matching.

Test Plan:
- Reset: hold rst for 3 cycles during an active scan -> all outputs 0, stale=0; the first commit needs a fresh MATCH_N scans.
- Clean scan: digits 3..0 showing 4F,5B,30,7E, each anode low for 20 cycles, 2 full rounds -> value=16'hE510, digit_valid=4'hF, exactly 4 upd pulses.
- Glyph sweep: digit 0 driven with every table code in turn, 2 scans each -> value[3:0] steps 0..F; also drive 73 -> 9 and 1F -> b.
- Blank/illegal: digit 2 shows 00 then 01 -> digit_blank[2]=1 then digit_illegal[2]=1, value[11:8]=0, digit_valid[2]=0.
- Glitch/multi-anode: a single-scan 6D on digit 1 between stable 79 scans, then an_in=4'b1100 -> value[7:4] stays 3, no sample taken on the multi-anode pattern.
- Timeout: stop scanning (an_in=4'hF) for 1000+ cycles -> stale=1, all flags 0, one upd; resume -> stale=0 after the first SAMPLE. With SEVENSEG_CAPTURE_DP_EN defined, dp_in=1 on digit 1 -> dp_out=4'b0010.

Source files
------------

// File: rtl/sevenseg_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sevenseg_capture                                             |
// | Description : Watches a multiplexed 4-digit 7-segment bus (segments plus   |
// |               active-low anodes). It recovers the hex nibble shown on each |
// |               digit and flags it as stable, blank or an illegal glyph.     |
// |               Optional: define SEVENSEG_CAPTURE_DP_EN to capture the       |
// |               decimal point of each digit into dp_out.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sevenseg_capture #(
    parameter int SETTLE_CYC  = 4,
    parameter int MATCH_N     = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic        dp_in,
    input  logic [3:0]  an_in,
    output logic [15:0] value,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_blank,
    output logic [3:0]  digit_illegal,
    output logic [3:0]  dp_out,
    output logic        upd,
    output logic        stale
);

    localparam logic [1:0]  c_ST_IDLE     = 2'd0;
    localparam logic [1:0]  c_ST_SETTLE   = 2'd1;
    localparam logic [1:0]  c_ST_SAMPLE   = 2'd2;
    localparam logic [1:0]  c_ST_WAIT_REL = 2'd3;

    localparam logic [1:0]  c_CLS_HEX     = 2'd0;
    localparam logic [1:0]  c_CLS_BLANK   = 2'd1;
    localparam logic [1:0]  c_CLS_ILL     = 2'd2;

    localparam logic [7:0]  c_SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [3:0]  c_MATCH       = 4'(MATCH_N);
    localparam logic [15:0] c_TO_LAST     = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] c_TO_MAX      = 16'(TIMEOUT_CYC);

    logic [6:0]  r_seg_s1, r_seg_s2;
    logic [3:0]  r_an_s1, r_an_s2;
    logic [1:0]  r_state, w_state_nxt;
    logic [3:0]  r_an_lat;
    logic [1:0]  r_sel;
    logic [7:0]  r_settle;
    logic        w_an_single;
    logic [1:0]  w_an_idx;
    logic [1:0]  w_dec_cls;
    logic [3:0]  w_dec_nib;
    logic        w_dp_samp;
    logic        w_dp_cur;
    logic [1:0]  r_cand_cls [4];
    logic [3:0]  r_cand_nib [4];
    logic        r_cand_dp  [4];
    logic [3:0]  r_match    [4];
    logic        w_is_sample;
    logic        w_same;
    logic [3:0]  w_match_nxt;
    logic [3:0]  w_new_nib;
    logic        w_differs;
    logic        w_commit;
    logic [15:0] r_to_cnt;
    logic        w_to_fire;
    logic [15:0] r_value;
    logic [3:0]  r_valid, r_blank, r_illegal;
    logic        r_upd, r_stale;

    // Two-flop synchronisers for the asynchronous segment and anode lines
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_s1 <= 7'h00;
            r_seg_s2 <= 7'h00;
            r_an_s1  <= 4'h0;
            r_an_s2  <= 4'h0;
        end else begin
            r_seg_s1 <= seg_in;
            r_seg_s2 <= r_seg_s1;
            r_an_s1  <= an_in;
            r_an_s2  <= r_an_s1;
        end
    end

`ifdef SEVENSEG_CAPTURE_DP_EN
    logic       r_dp_s1, r_dp_s2;
    logic [3:0] r_dp_out;

    // Decimal-point synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_s1 <= 1'b0;
            r_dp_s2 <= 1'b0;
        end else begin
            r_dp_s1 <= dp_in;
            r_dp_s2 <= r_dp_s1;
        end
    end

    // Committed decimal point per digit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_out <= 4'h0;
        end else if (w_commit) begin
            r_dp_out[r_sel] <= w_dp_samp;
        end
    end

    assign w_dp_samp = r_dp_s2;
    assign w_dp_cur  = r_dp_out[r_sel];
    assign dp_out    = r_dp_out;
`else
    logic w_dp_unused;
    assign w_dp_unused = dp_in;
    assign w_dp_samp   = 1'b0;
    assign w_dp_cur    = 1'b0;
    assign dp_out      = 4'b0000;
`endif

    // Exactly one low anode is a valid selection; all-high or multi-low is not
    always_comb begin
        w_an_single = 1'b1;
        w_an_idx    = 2'd0;
        case (r_an_s2)
            4'b1110: w_an_idx = 2'd0;
            4'b1101: w_an_idx = 2'd1;
            4'b1011: w_an_idx = 2'd2;
            4'b0111: w_an_idx = 2'd3;
            default: w_an_single = 1'b0;
        endcase
    end

    // Glyph lookup: segment code to class plus nibble
    always_comb begin
        w_dec_cls = c_CLS_HEX;
        w_dec_nib = 4'h0;
        case (r_seg_s2)
            7'h7E: w_dec_nib = 4'h0;
            7'h30: w_dec_nib = 4'h1;
            7'h6D: w_dec_nib = 4'h2;
            7'h79: w_dec_nib = 4'h3;
            7'h33: w_dec_nib = 4'h4;
            7'h5B: w_dec_nib = 4'h5;
            7'h5F: w_dec_nib = 4'h6;
            7'h70: w_dec_nib = 4'h7;
            7'h7F: w_dec_nib = 4'h8;
            7'h73: w_dec_nib = 4'h9;
            7'h77: w_dec_nib = 4'hA;
            7'h1F: w_dec_nib = 4'hB;
            7'h4E: w_dec_nib = 4'hC;
            7'h3D: w_dec_nib = 4'hD;
            7'h4F: w_dec_nib = 4'hE;
            7'h47: w_dec_nib = 4'hF;
            7'h00: w_dec_cls = c_CLS_BLANK;
            default: w_dec_cls = c_CLS_ILL;
        endcase
    end

    // Scan FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Scan FSM next state: select, settle, sample once, wait for release
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:     if (w_an_single) w_state_nxt = c_ST_SETTLE;
            c_ST_SETTLE: begin
                if (r_an_s2 != r_an_lat)            w_state_nxt = c_ST_IDLE;
                else if (r_settle == c_SETTLE_LAST) w_state_nxt = c_ST_SAMPLE;
            end
            c_ST_SAMPLE:   w_state_nxt = c_ST_WAIT_REL;
            c_ST_WAIT_REL: if (r_an_s2 != r_an_lat) w_state_nxt = c_ST_IDLE;
            default:       w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Latch the selected anode pattern and count settle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an_lat <= 4'h0;
            r_sel    <= 2'd0;
            r_settle <= 8'd0;
        end else if (r_state == c_ST_IDLE) begin
            if (w_an_single) begin
                r_an_lat <= r_an_s2;
                r_sel    <= w_an_idx;
                r_settle <= 8'd0;
            end
        end else if (r_state == c_ST_SETTLE) begin
            r_settle <= r_settle + 8'd1;
        end
    end

    // Compare the fresh decode with the candidate and the committed state
    always_comb begin
        w_is_sample = (r_state == c_ST_SAMPLE);
        w_same      = ({w_dec_cls, w_dec_nib, w_dp_samp} ==
                       {r_cand_cls[r_sel], r_cand_nib[r_sel], r_cand_dp[r_sel]});
        if (!w_same)                    w_match_nxt = 4'd1;
        else if (r_match[r_sel] >= c_MATCH) w_match_nxt = c_MATCH;
        else                            w_match_nxt = r_match[r_sel] + 4'd1;
        w_new_nib = (w_dec_cls == c_CLS_HEX) ? w_dec_nib : 4'h0;
        w_differs = ({w_dec_cls == c_CLS_HEX, w_dec_cls == c_CLS_BLANK,
                      w_dec_cls == c_CLS_ILL, w_new_nib, w_dp_samp} !=
                     {r_valid[r_sel], r_blank[r_sel], r_illegal[r_sel],
                      r_value[{r_sel, 2'b00} +: 4], w_dp_cur});
        w_commit  = w_is_sample && (w_match_nxt == c_MATCH) && w_differs;
        w_to_fire = !w_is_sample && (r_to_cnt == c_TO_LAST);
    end

    // Per-digit candidate and match counter, updated on every sample
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_cand_cls[k] <= 2'd0;
                r_cand_nib[k] <= 4'h0;
                r_cand_dp[k]  <= 1'b0;
                r_match[k]    <= 4'd0;
            end
        end else if (w_is_sample) begin
            r_cand_cls[r_sel] <= w_dec_cls;
            r_cand_nib[r_sel] <= w_dec_nib;
            r_cand_dp[r_sel]  <= w_dp_samp;
            r_match[r_sel]    <= w_match_nxt;
        end
    end

    // Saturating scan timeout counter and stale flag; a sample always wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= 16'd0;
            r_stale  <= 1'b0;
        end else if (w_is_sample) begin
            r_to_cnt <= 16'd0;
            r_stale  <= 1'b0;
        end else begin
            if (r_to_cnt != c_TO_MAX) r_to_cnt <= r_to_cnt + 16'd1;
            if (w_to_fire)            r_stale  <= 1'b1;
        end
    end

    // Committed outputs and the change pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value   <= 16'h0000;
            r_valid   <= 4'h0;
            r_blank   <= 4'h0;
            r_illegal <= 4'h0;
            r_upd     <= 1'b0;
        end else begin
            r_upd <= w_commit || w_to_fire;
            if (w_commit) begin
                r_value[{r_sel, 2'b00} +: 4] <= w_new_nib;
                r_valid[r_sel]               <= (w_dec_cls == c_CLS_HEX);
                r_blank[r_sel]               <= (w_dec_cls == c_CLS_BLANK);
                r_illegal[r_sel]             <= (w_dec_cls == c_CLS_ILL);
            end else if (w_to_fire) begin
                r_value   <= 16'h0000;
                r_valid   <= 4'h0;
                r_blank   <= 4'h0;
                r_illegal <= 4'h0;
            end
        end
    end

    assign value         = r_value;
    assign digit_valid   = r_valid;
    assign digit_blank   = r_blank;
    assign digit_illegal = r_illegal;
    assign upd           = r_upd;
    assign stale         = r_stale;

endmodule
`default_nettype wire
